// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter: FSM states, requester identity and L2 operation.
package l2_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundles the I-side, D-side and L2 handshake signals seen by the arbiter.
interface l2_arbiter_if #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_read;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_read;
  logic                  d_write;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic [ADDR_WIDTH-1:0] l2_addr;
  logic                  l2_read;
  logic                  l2_write;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  // The arbiter is the master of the L2 port and the responder to both L1s.
  modport master (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_addr, l2_read, l2_write, l2_wdata
  );

  modport slave (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_addr, l2_read, l2_write, l2_wdata
  );

endinterface

// File: rtl/l2_arb_hold_reg.sv
// Hold registers for the granted request; the only source of the L2 address, data and op.
module l2_arb_hold_reg
  import l2_arb_types::*;
#(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  input  op_e                   i_op,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [LINE_WIDTH-1:0] o_wdata,
  output op_e                   o_op
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  op_e                   r_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_READ;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_op    <= i_op;
    end
  end

  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_op    = r_op;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-side and D-side L1 caches,
// one transaction at a time, with per-requester grant counters.
module l2_arbiter
  import l2_arb_types::*;
#(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  l2_arbiter_if.master bus,
  output logic [31:0]  i_grant_count,
  output logic [31:0]  d_grant_count
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  requester_t r_last_served;
  logic [LINE_WIDTH-1:0] r_ret_data;
  logic [31:0] r_i_grant_count;
  logic [31:0] r_d_grant_count;

  logic w_i_pend;
  logic w_d_pend;
  logic w_grant_i;
  logic w_grant_d;
  logic w_load;
  logic w_granted;
  logic w_done;

  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic [LINE_WIDTH-1:0] w_ld_wdata;
  op_e                   w_ld_op;
  logic [ADDR_WIDTH-1:0] w_hold_addr;
  logic [LINE_WIDTH-1:0] w_hold_wdata;
  op_e                   w_hold_op;

  assign w_i_pend = bus.i_read;
  assign w_d_pend = bus.d_read | bus.d_write;

  // On a tie the requester that was not served last wins.
  assign w_grant_d = (r_state == IDLE) && w_d_pend && (!w_i_pend || (r_last_served == REQ_I));
  assign w_grant_i = (r_state == IDLE) && w_i_pend && !w_grant_d;
  assign w_load    = w_grant_i | w_grant_d;

  assign w_ld_addr  = w_grant_d ? bus.d_addr : bus.i_addr;
  assign w_ld_wdata = w_grant_d ? bus.d_wdata : '0;
  assign w_ld_op    = (w_grant_d && bus.d_write) ? OP_WRITE : OP_READ;

  l2_arb_hold_reg #(
    .LINE_WIDTH(LINE_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_addr (w_ld_addr),
    .i_wdata(w_ld_wdata),
    .i_op   (w_ld_op),
    .o_addr (w_hold_addr),
    .o_wdata(w_hold_wdata),
    .o_op   (w_hold_op)
  );

  assign w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign w_done    = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d)      w_state_nxt = GRANT_D;
        else if (w_grant_i) w_state_nxt = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (bus.l2_resp) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_last_served   <= REQ_I;
      r_ret_data      <= '0;
      r_i_grant_count <= '0;
      r_d_grant_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_d) begin
        r_last_served   <= REQ_D;
        r_d_grant_count <= r_d_grant_count + 32'd1;
      end else if (w_grant_i) begin
        r_last_served   <= REQ_I;
        r_i_grant_count <= r_i_grant_count + 32'd1;
      end
      // Writes clear the return register so no stale line reaches the D-side.
      if (w_granted && bus.l2_resp) begin
        r_ret_data <= (w_hold_op == OP_WRITE) ? '0 : bus.l2_rdata;
      end
    end
  end

  assign bus.l2_addr  = w_granted ? w_hold_addr : '0;
  assign bus.l2_wdata = w_granted ? w_hold_wdata : '0;
  assign bus.l2_read  = w_granted && (w_hold_op == OP_READ);
  assign bus.l2_write = w_granted && (w_hold_op == OP_WRITE);

  assign bus.i_resp  = w_done && (r_last_served == REQ_I);
  assign bus.d_resp  = w_done && (r_last_served == REQ_D);
  assign bus.i_rdata = bus.i_resp ? r_ret_data : '0;
  assign bus.d_rdata = bus.d_resp ? r_ret_data : '0;

  assign i_grant_count = r_i_grant_count;
  assign d_grant_count = r_d_grant_count;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a cycle table for arbitration plus hand-written corner cases.
module tb_l2_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] i_grant_count;
  logic [31:0] d_grant_count;

  int n_checks = 0;
  int n_errors = 0;

  l2_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  l2_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_grant_count(i_grant_count),
    .d_grant_count(d_grant_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_addr   = '0;
    bus.i_read   = 1'b0;
    bus.d_addr   = '0;
    bus.d_read   = 1'b0;
    bus.d_write  = 1'b0;
    bus.d_wdata  = '0;
    bus.l2_rdata = '0;
    bus.l2_resp  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] ctl_outs();
    return {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp};
  endfunction

  // Row layout: {i_read, d_read, d_write, l2_resp, exp l2_read, exp l2_write, exp i_resp, exp d_resp}
  typedef struct packed {
    logic       i_read;
    logic       d_read;
    logic       d_write;
    logic       l2_resp;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[19];

  logic [LW-1:0] a5_line;
  logic [LW-1:0] wline;
  logic [LW-1:0] ff_line;

  initial begin
    tbl[0]  = 8'b1100_0000;  // tie from reset: D should win
    tbl[1]  = 8'b1101_1000;  // GRANT_D, L2 answers
    tbl[2]  = 8'b1100_0001;  // DONE, d_resp
    tbl[3]  = 8'b1000_0000;  // IDLE, I granted
    tbl[4]  = 8'b1001_1000;  // GRANT_I, L2 answers
    tbl[5]  = 8'b1100_0010;  // DONE, i_resp; D raises a new request which must wait
    tbl[6]  = 8'b1100_0000;  // IDLE, repeated tie: D wins again
    tbl[7]  = 8'b1101_1000;
    tbl[8]  = 8'b1100_0001;
    tbl[9]  = 8'b1000_0000;
    tbl[10] = 8'b1000_1000;  // GRANT_I, L2 slow
    tbl[11] = 8'b1001_1000;
    tbl[12] = 8'b1000_0010;
    tbl[13] = 8'b0000_0000;
    tbl[14] = 8'b0110_0000;  // read and write together -> write
    tbl[15] = 8'b0111_0100;
    tbl[16] = 8'b0110_0001;
    tbl[17] = 8'b0000_0000;
    tbl[18] = 8'b0000_0000;

    a5_line = {32{8'hA5}};
    wline   = {8{32'h1234_5678}};
    ff_line = {LW{1'b1}};

    // Reset state
    do_reset();
    check("rst_ctl", LW'(ctl_outs()), LW'(4'b0000));
    check("rst_l2_addr", LW'(bus.l2_addr), '0);
    check("rst_i_cnt", LW'(i_grant_count), '0);
    check("rst_d_cnt", LW'(d_grant_count), '0);

    // I read with 5-cycle L2 latency
    bus.i_addr = 32'h0000_1000;
    bus.i_read = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("rd_l2_read_c%0d", c), LW'(bus.l2_read), LW'(1'b1));
      if (c == 1) begin
        check("rd_l2_addr", LW'(bus.l2_addr), LW'(32'h0000_1000));
        check("rd_l2_write", LW'(bus.l2_write), '0);
      end
      if (c == 5) begin
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = a5_line;
      end
      tick();
    end
    bus.l2_resp  = 1'b0;
    bus.l2_rdata = '0;
    check("rd_c6_ctl", LW'(ctl_outs()), LW'(4'b0010));
    check("rd_i_rdata", bus.i_rdata, a5_line);
    check("rd_d_rdata", bus.d_rdata, '0);
    check("rd_i_cnt", LW'(i_grant_count), LW'(32'd1));
    bus.i_read = 1'b0;
    tick();
    check("rd_c7_ctl", LW'(ctl_outs()), LW'(4'b0000));
    check("rd_c7_i_rdata", bus.i_rdata, '0);

    // Arbitration table from a fresh reset
    do_reset();
    for (int r = 0; r < 19; r++) begin
      bus.i_read  = tbl[r].i_read;
      bus.d_read  = tbl[r].d_read;
      bus.d_write = tbl[r].d_write;
      bus.l2_resp = tbl[r].l2_resp;
      check($sformatf("tbl_row%0d", r), LW'(ctl_outs()), LW'(tbl[r].exp));
      tick();
    end
    clear_inputs();
    check("tbl_i_cnt", LW'(i_grant_count), LW'(32'd2));
    check("tbl_d_cnt", LW'(d_grant_count), LW'(32'd3));

    // D write; inputs changed mid-grant must not reach the L2
    do_reset();
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_2020;
    bus.d_wdata = wline;
    tick();
    bus.d_addr  = 32'hDEAD_0000;
    bus.d_wdata = ff_line;
    check("wr_l2_addr", LW'(bus.l2_addr), LW'(32'h0000_2020));
    check("wr_l2_wdata", bus.l2_wdata, wline);
    check("wr_ctl", LW'(ctl_outs()), LW'(4'b0100));
    tick();
    check("wr_l2_addr_held", LW'(bus.l2_addr), LW'(32'h0000_2020));
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = ff_line;
    tick();
    bus.l2_resp  = 1'b0;
    bus.l2_rdata = '0;
    check("wr_done_ctl", LW'(ctl_outs()), LW'(4'b0001));
    check("wr_d_rdata", bus.d_rdata, '0);
    bus.d_write = 1'b0;
    tick();
    check("wr_after_ctl", LW'(ctl_outs()), LW'(4'b0000));

    // Reset in the middle of GRANT_I
    do_reset();
    bus.i_addr = 32'h0000_4000;
    bus.i_read = 1'b1;
    tick();
    check("mid_pre_ctl", LW'(ctl_outs()), LW'(4'b1000));
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", LW'(ctl_outs()), LW'(4'b0000));
    check("mid_rst_addr", LW'(bus.l2_addr), '0);
    check("mid_rst_i_cnt", LW'(i_grant_count), '0);
    bus.i_read = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mid_after_ctl%0d", c), LW'(ctl_outs()), LW'(4'b0000));
    end

    // D grant counter wraps
    do_reset();
    force dut.r_d_grant_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_d_grant_count;
    bus.d_read = 1'b1;
    tick();
    check("wrap_d_cnt", LW'(d_grant_count), '0);
    check("wrap_i_cnt", LW'(i_grant_count), '0);
    bus.l2_resp = 1'b1;
    tick();
    bus.l2_resp = 1'b0;
    check("wrap_d_resp", LW'(ctl_outs()), LW'(4'b0001));
    bus.d_read = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
